wrr_packet_arbiter: RTL and testbench
=====================================

Name: wrr_packet_arbiter

Overview:
- Parametrised successor to the round-robin arbiter, for packet-based traffic.
- Grants one of N requesters per cycle using weighted round-robin. Each requester may win up to weight[i] consecutive packets before priority rotates.
- A grant is held across multi-beat packets (lock until last beat), and it advances only on a valid/ready handshake with the downstream sink.
- Sits in front of shared links and shared memory ports where plain one-shot round-robin causes packet interleaving and starvation under bursty load.

Parameters:
- N, 4, number of requesters (N >= 2).
- W, 4, width of each per-requester weight field.
- IDXW, $clog2(N), width of grant_idx.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset; state clears while rst == 0.
- request  input  N  per-requester beat valid; must stay high from the first to the last beat of a packet.
- last  input  N  per-requester end-of-packet flag, qualified by request[i].
- weight  input  N*W  weight of requester i in bits [i*W +: W]; value 0 is treated as 1.
- ready  input  1  downstream accepts the granted beat this cycle.
- grant  output  N  one-hot grant, combinational from state and request.
- grant_valid  output  1  equals |grant.
- grant_idx  output  IDXW  binary index of the grant; 0 when grant_valid == 0.
- locked  output  1  registered; a packet is in progress.

Behaviour:
- State registers:
  - p: N-bit one-hot priority pointer.
  - cnt: W-bit packets served at the current pointer.
  - lock: 1 bit.
  - owner: IDXW bits.
- Reset (rst == 0, asynchronous): p = 1 (index 0), cnt = 0, lock = 0, owner = 0.
  - locked = 0.
  - grant / grant_valid / grant_idx follow the combinational rules below; with request == 0 all are 0.
- Unlocked arbitration: grant selects the first set request[] bit searching circularly from the index of p upward (wrapping N-1 -> 0). Zero-latency, same cycle.
- Locked arbitration:
  - grant = onehot(owner) if request[owner] == 1, else 0.
  - Other requesters are never granted while locked.
- Transfer: occurs when grant_valid && ready. g denotes the granted index.
  - No transfer means no state change. Grant must remain stable under ready == 0 while request is unchanged.
- Non-last transfer (last[g] == 0): lock <= 1, owner <= g; p and cnt unchanged.
- Last transfer (last[g] == 1):
  - lock <= 0.
  - eff_w = (weight[g] == 0) ? 1 : weight[g].
  - cnt_n = (onehot(g) == p) ? cnt + 1 : 1, computed in W+1 bits (no wrap).
  - If cnt_n >= eff_w: p <= rotate-left-by-one of onehot(g) (g = N-1 wraps to bit 0), cnt <= 0.
  - Otherwise: p <= onehot(g), cnt <= cnt_n. The same requester keeps top priority for its next packet.
- Single-beat packet: first beat has last = 1; behaves as a last transfer and never sets lock.
- weight is sampled only at a last transfer. Changes mid-packet take effect at that packet's end.
- Owner drops request while locked (protocol violation): grant = 0, lock stays 1, no other requester is served. Recovery is only by the owner's last beat or by reset.
- Reset asserted mid-packet: lock clears immediately and p returns to index 0. No partial-packet memory remains.
- p is always exactly one-hot. An assertion in the bench checks this, and checks that grant is one-hot or zero.

Test Plan:
- Round robin, all weights 1: request = 4'b1111, last = 4'b1111, ready = 1 from reset -> grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- Weighted: weight = {1,1,1,3} (index 3..0), all requesting single-beat, ready = 1 -> grant_idx sequence 0,0,0,1,2,3,0,0,0,1.
- Packet lock:
  - request = 4'b0011, req0 sends 4 beats with last0 = 1 only on beat 4, ready = 1 -> grant = 0001 for 4 cycles, locked = 1 on cycles 2-4 and drops after beat 4.
  - Next grant is 0010.
- Backpressure and violation:
  - ready = 0 for 5 cycles mid-packet -> grant constant, locked constant, p and cnt unchanged.
  - Owner drops request while locked -> grant = 0, grant_valid = 0, locked = 1.
- Boundaries:
  - weight0 = 0 behaves as 1.
  - Only request[3] active from reset (p at index 0) -> grant = 1000. After its last beat with weight 1, p wraps to 0001.
  - A requester not at the pointer that wins starts with cnt = 1.
- Async reset: pull rst low mid 4-beat packet between clock edges -> locked = 0 immediately. After release, with all requesting, the first grant is 0001.

Source files
------------

// File: rtl/wrr_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_packet_arbiter
//  Description : Weighted round-robin arbiter for N packet requesters. The
//                grant locks to one owner until its last beat and advances
//                only on a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrr_packet_arbiter #(
    parameter int N    = 4,
    parameter int W    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    request,
    input  logic [N-1:0]    last,
    input  logic [N*W-1:0]  weight,
    input  logic            ready,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic            locked
);

    localparam logic [0:0]   c_ST_OPEN   = 1'b0;
    localparam logic [0:0]   c_ST_LOCKED = 1'b1;
    localparam logic [N-1:0] c_PTR_RESET = {{(N-1){1'b0}}, 1'b1};
    localparam logic [W:0]   c_CNT_ONE   = {{W{1'b0}}, 1'b1};

    logic [0:0]      r_state;
    logic [N-1:0]    r_ptr;
    logic [W-1:0]    r_cnt;
    logic [IDXW-1:0] r_owner;

    logic [0:0]      w_state_nxt;
    logic [N-1:0]    w_ptr_nxt;
    logic [W-1:0]    w_cnt_nxt;
    logic [IDXW-1:0] w_owner_nxt;

    logic [W-1:0]    w_weights [N];
    logic [IDXW-1:0] w_ptr_idx;
    logic            w_sel_found;
    logic [IDXW-1:0] w_sel_idx;
    logic            w_xfer;
    logic [W:0]      w_eff_w;
    logic [W:0]      w_cnt_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_weight_unpack
            assign w_weights[gi] = weight[gi*W +: W];
        end
    endgenerate

    always_comb begin
        w_ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (r_ptr[i]) begin
                w_ptr_idx = w_ptr_idx | IDXW'(i);
            end
        end
    end

    // Circular search for the first active request starting at the pointer.
    always_comb begin
        int j;
        j           = 0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(w_ptr_idx) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!w_sel_found && request[j]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDXW'(j);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_OPEN;
            r_ptr   <= c_PTR_RESET;
            r_cnt   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign w_xfer  = grant_valid && ready;
    assign w_eff_w = (w_weights[grant_idx] == '0) ? c_CNT_ONE : {1'b0, w_weights[grant_idx]};

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_cnt_inc   = '0;
        if (w_xfer) begin
            if (!last[grant_idx]) begin
                w_state_nxt = c_ST_LOCKED;
                w_owner_nxt = grant_idx;
            end else begin
                w_state_nxt = c_ST_OPEN;
                // A winner that is not at the pointer starts a fresh quota of one.
                w_cnt_inc = (grant == r_ptr) ? ({1'b0, r_cnt} + c_CNT_ONE) : c_CNT_ONE;
                if (w_cnt_inc >= w_eff_w) begin
                    w_ptr_nxt = {grant[N-2:0], grant[N-1]};
                    w_cnt_nxt = '0;
                end else begin
                    w_ptr_nxt = grant;
                    w_cnt_nxt = w_cnt_inc[W-1:0];
                end
            end
        end
    end

    // Output logic
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (r_state == c_ST_LOCKED) begin
            if (request[r_owner]) begin
                grant[r_owner] = 1'b1;
                grant_idx      = r_owner;
            end
        end else if (w_sel_found) begin
            grant[w_sel_idx] = 1'b1;
            grant_idx        = w_sel_idx;
        end
        grant_valid = |grant;
        locked      = (r_state == c_ST_LOCKED);
    end

endmodule
`default_nettype wire

// File: tb/tb_wrr_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wrr_packet_arbiter
//  Description : Scoreboard bench for wrr_packet_arbiter with directed
//                scenarios and randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wrr_packet_arbiter;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    request;
    logic [N-1:0]    last;
    logic [N*W-1:0]  weight;
    logic            ready;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;
    logic            locked;

    wrr_packet_arbiter #(.N(N), .W(W), .IDXW(IDXW)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .request     (request),
        .last        (last),
        .weight      (weight),
        .ready       (ready),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    grant;
        logic [IDXW-1:0] idx;
        logic            vld;
        logic            lk;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: pointer index, packets served there, current packet owner (-1 = none)
    int m_ptr;
    int m_cnt;
    int m_owner;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_ptr   = 0;
        m_cnt   = 0;
        m_owner = -1;
    endfunction

    function automatic int model_pick(input logic [N-1:0] req);
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_xfer(input int g, input logic is_last, input int w);
        int eff;
        int cn;
        if (!is_last) begin
            m_owner = g;
            return;
        end
        m_owner = -1;
        eff = (w == 0) ? 1 : w;
        cn  = (g == m_ptr) ? m_cnt + 1 : 1;
        if (cn >= eff) begin
            m_ptr = (g + 1) % N;
            m_cnt = 0;
        end else begin
            m_ptr = g;
            m_cnt = cn;
        end
    endfunction

    // exp_idx: -1 = no directed check, -2 = no grant expected, else the index expected
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] lst,
                        input logic rdy, input int exp_idx);
        exp_t e;
        int   g;
        request = req;
        last    = lst;
        ready   = rdy;
        g       = model_pick(req);
        e.grant = '0;
        if (g >= 0) e.grant[g] = 1'b1;
        e.idx = (g >= 0) ? IDXW'(g) : '0;
        e.vld = (g >= 0);
        e.lk  = (m_owner >= 0);
        sb.push_back(e);
        #1;
        if (exp_idx == -2) begin
            check("directed_no_grant", {31'd0, grant_valid}, 32'd0);
        end else if (exp_idx >= 0) begin
            check("directed_idx", {grant_valid, 29'd0, grant_idx}, {1'b1, 29'd0, exp_idx[1:0]});
        end
        @(posedge clk);
        if (g >= 0 && rdy) model_xfer(g, lst[g], int'(weight[g*W +: W]));
        #1;
    endtask

    task automatic do_reset();
        request = '0;
        last    = '0;
        ready   = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_locked", {31'd0, locked}, 32'd0);
        check("reset_grant", {27'd0, grant_valid, grant}, 32'd0);
        check("reset_idx", {30'd0, grant_idx}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor, sampling mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("grant", {28'd0, grant}, {28'd0, e.grant});
            check("grant_idx", {30'd0, grant_idx}, {30'd0, e.idx});
            check("grant_valid", {31'd0, grant_valid}, {31'd0, e.vld});
            check("locked", {31'd0, locked}, {31'd0, e.lk});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            assert ($onehot(dut.r_ptr)) else begin
                n_bad++;
                $display("FAIL ptr_onehot: got %b expected one-hot", dut.r_ptr);
            end
            assert ($onehot0(grant)) else begin
                n_bad++;
                $display("FAIL grant_onehot0: got %b expected one-hot or zero", grant);
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        rst_n   = 1'b0;
        weight  = 16'h1111;
        request = '0;
        last    = '0;
        ready   = 1'b0;
        model_reset();

        // Plain round robin
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b1111, 4'b1111, 1'b1, i % 4);

        // Weighted: requester 0 has weight 3
        weight = {4'd1, 4'd1, 4'd1, 4'd3};
        do_reset();
        begin
            int seq [10] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1};
            for (int i = 0; i < 10; i++) step(4'b1111, 4'b1111, 1'b1, seq[i]);
        end

        // Packet lock: four beats from requester 0
        weight = 16'h1111;
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0011, 4'b0000, 1'b1, 0);
        step(4'b0011, 4'b0001, 1'b1, 0);
        step(4'b0011, 4'b0011, 1'b1, 1);

        // Backpressure mid-packet, then owner drops request
        do_reset();
        step(4'b0011, 4'b0000, 1'b1, 0);
        step(4'b0011, 4'b0000, 1'b1, 0);
        for (int i = 0; i < 5; i++) step(4'b0011, 4'b0000, 1'b0, 0);
        step(4'b0010, 4'b0000, 1'b1, -2);
        step(4'b0010, 4'b0010, 1'b1, -2);
        step(4'b0011, 4'b0001, 1'b1, 0);
        step(4'b0011, 4'b0011, 1'b1, 1);

        // Zero weight behaves as one
        weight = {4'd1, 4'd1, 4'd1, 4'd0};
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b1111, 4'b1111, 1'b1, i % 4);

        // Only the top requester, then pointer wraps to 0
        weight = 16'h1111;
        do_reset();
        step(4'b1000, 4'b1000, 1'b1, 3);
        step(4'b1111, 4'b1111, 1'b1, 0);

        // Winner away from the pointer starts with a count of one
        weight = 16'h2222;
        do_reset();
        step(4'b0010, 4'b0010, 1'b1, 1);
        step(4'b1111, 4'b1111, 1'b1, 1);
        step(4'b1111, 4'b1111, 1'b1, 2);
        step(4'b1111, 4'b1111, 1'b1, 2);
        step(4'b1111, 4'b1111, 1'b1, 3);
        step(4'b1111, 4'b1111, 1'b1, 3);

        // Asynchronous reset in the middle of a packet
        weight = 16'h1111;
        do_reset();
        step(4'b0001, 4'b0000, 1'b1, 0);
        step(4'b0001, 4'b0000, 1'b1, 0);
        check("locked_before_async_rst", {31'd0, locked}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("locked_async_rst", {31'd0, locked}, 32'd0);
        model_reset();
        request = 4'b1111;
        last    = 4'b1111;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1111, 4'b1111, 1'b1, 0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                for (int i = 0; i < N; i++) weight[i*W +: W] = W'($urandom_range(0, 3));
            end
            rq = N'($urandom);
            if (m_owner >= 0 && ($urandom % 8) != 0) rq[m_owner] = 1'b1;
            step(rq, N'($urandom) & N'($urandom), ($urandom % 4) != 0, -1);
        end

        #10;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
